wr_data_packer: RTL and testbench

//  Write-direction counterpart of the rd_fifo 128->32 read path: packs a stream of
//  32-bit pixel/data words into 128-bit words and pushes them into the 128-bit-wide

---
 rtl/wr_data_packer_if.sv | 38 +++
 rtl/wr_data_packer.sv | 130 +++++++++++++
 tb/tb_wr_data_packer.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wr_data_packer_if.sv
// ---------------------------------------------------------------------------
// wr_data_packer_if
// Bundles the packer's input stream, FIFO write port and status signals.
//   master : producer/testbench side (drives in_*, wr_full)
//   slave  : packer side (drives in_ready, wr_*, frame_words, busy)
// Signals:
//   in_valid/in_ready/in_data/in_last : 32-bit input stream with end-of-frame
//   wr_full                           : write FIFO full flag
//   wr_en/wr_data/wr_last             : 128-bit FIFO write port
//   frame_words                       : 128-bit words written in current frame
//   busy                              : packer holds undelivered data
// ---------------------------------------------------------------------------
interface wr_data_packer_if #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 128,
  parameter int CNT_WIDTH = 11
);
  logic                 in_valid;
  logic                 in_ready;
  logic [IN_WIDTH-1:0]  in_data;
  logic                 in_last;
  logic                 wr_full;
  logic                 wr_en;
  logic [OUT_WIDTH-1:0] wr_data;
  logic                 wr_last;
  logic [CNT_WIDTH-1:0] frame_words;
  logic                 busy;

  modport master (
    output in_valid, in_data, in_last, wr_full,
    input  in_ready, wr_en, wr_data, wr_last, frame_words, busy
  );

  modport slave (
    input  in_valid, in_data, in_last, wr_full,
    output in_ready, wr_en, wr_data, wr_last, frame_words, busy
  );
endinterface

// File: rtl/wr_data_packer.sv
// ---------------------------------------------------------------------------
// wr_data_packer
// Packs a stream of IN_WIDTH-bit words into OUT_WIDTH-bit words (4 lanes for
// the default 32->128) and pushes them into a write FIFO. The first word of a
// group lands in the lowest lane. A word accepted with in_last closes the
// group early; unfilled upper lanes are filled with PAD_VALUE.
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : wr_data_packer_if.slave (input stream, FIFO write port, status)
// Storage is two stages: an accumulator for lanes 0..RATIO-2 plus a lane
// counter, and one pending output register that feeds the FIFO directly.
// ---------------------------------------------------------------------------
module wr_data_packer #(
  parameter int                  IN_WIDTH  = 32,
  parameter int                  OUT_WIDTH = 128,
  parameter logic [IN_WIDTH-1:0] PAD_VALUE = 32'h0,
  parameter int                  CNT_WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst,
  wr_data_packer_if.slave  bus
);

  localparam int RATIO  = OUT_WIDTH / IN_WIDTH;
  localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [LANE_W-1:0]    LAST_LANE = LANE_W'(RATIO - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};

  // Accumulator and lane counter
  logic [LANE_W-1:0]                cnt_r;
  logic [RATIO-2:0][IN_WIDTH-1:0]   acc_r;

  // Pending output register
  logic                 pend_vld_r;
  logic [OUT_WIDTH-1:0] pend_data_r;
  logic                 pend_last_r;

  // Frame word counter
  logic [CNT_WIDTH-1:0] frame_words_r;

  // Handshake and control terms
  logic                 wr_en_s;
  logic                 in_ready_s;
  logic                 accept_s;
  logic                 load_s;
  logic [OUT_WIDTH-1:0] packed_s;

  // The FIFO write happens on the same edge wr_en is seen high, so the pending
  // slot is free for a new load whenever the FIFO is not full.
  assign wr_en_s    = pend_vld_r && !bus.wr_full;
  assign in_ready_s = !pend_vld_r || !bus.wr_full;
  assign accept_s   = bus.in_valid && in_ready_s;
  assign load_s     = accept_s && ((cnt_r == LAST_LANE) || bus.in_last);

  // Build the outgoing word: lanes below cnt come from the accumulator, lane
  // cnt takes the incoming word, lanes above cnt are padding.
  for (genvar g = 0; g < RATIO; g++) begin : g_lane
    if (g < RATIO - 1) begin : g_acc_lane
      assign packed_s[g*IN_WIDTH +: IN_WIDTH] =
        (LANE_W'(g) < cnt_r)  ? acc_r[g]    :
        (LANE_W'(g) == cnt_r) ? bus.in_data : PAD_VALUE;
    end else begin : g_top_lane
      // Top lane is never held in the accumulator: it is only ever filled
      // directly by the word that completes the group.
      assign packed_s[g*IN_WIDTH +: IN_WIDTH] =
        (LANE_W'(g) == cnt_r) ? bus.in_data : PAD_VALUE;
    end
  end

  // Accumulator lanes and lane counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
      for (int i = 0; i < RATIO - 1; i++) begin
        acc_r[i] <= '0;
      end
    end else if (load_s) begin
      cnt_r <= '0;
      for (int i = 0; i < RATIO - 1; i++) begin
        acc_r[i] <= PAD_VALUE;
      end
    end else if (accept_s) begin
      cnt_r <= cnt_r + LANE_W'(1);
      for (int i = 0; i < RATIO - 1; i++) begin
        if (LANE_W'(i) == cnt_r) begin
          acc_r[i] <= bus.in_data;
        end
      end
    end
  end

  // Pending register: a load wins over a drain, so a drain and load in the
  // same cycle keeps pend_vld high with the new word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_vld_r  <= 1'b0;
      pend_data_r <= '0;
      pend_last_r <= 1'b0;
    end else if (load_s) begin
      pend_vld_r  <= 1'b1;
      pend_data_r <= packed_s;
      pend_last_r <= bus.in_last;
    end else if (wr_en_s) begin
      pend_vld_r  <= 1'b0;
    end
  end

  // Frame word counter: counts FIFO writes, clears after the frame's last
  // write, and saturates instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_words_r <= '0;
    end else if (wr_en_s) begin
      if (pend_last_r) begin
        frame_words_r <= '0;
      end else if (frame_words_r != CNT_MAX) begin
        frame_words_r <= frame_words_r + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.wr_en       = wr_en_s;
  assign bus.wr_data     = pend_data_r;
  assign bus.wr_last     = pend_last_r && wr_en_s;
  assign bus.frame_words = frame_words_r;
  assign bus.busy        = (cnt_r != '0) || pend_vld_r;

endmodule

// File: tb/tb_wr_data_packer.sv
module tb_wr_data_packer;
  localparam int IW = 32;
  localparam int OW = 128;
  localparam int CW = 11;
  localparam logic [31:0] PAD = 32'h0;
  localparam int FW_MAX = 2047;

  logic clk = 1'b0;
  logic rst;

  wr_data_packer_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .CNT_WIDTH(CW)) bus ();

  wr_data_packer #(
    .IN_WIDTH(IW), .OUT_WIDTH(OW), .PAD_VALUE(PAD), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: words collected for the current group, and the queue of
  // 128-bit words formed but not yet written to the FIFO.
  typedef struct {
    logic [127:0] data;
    logic         last;
  } wr_t;
  logic [31:0] grp[$];
  wr_t         exp_q[$];
  int          fw_model = 0;
  bit          mon_en = 1'b0;
  bit          acc_seen = 1'b0;
  int          full_mode = 0;

  typedef struct {
    logic         v;
    logic [31:0]  d;
    logic         l;
    logic         f;
    logic         rdy;
    logic         we;
    logic [127:0] wd;
    logic         wl;
    logic [10:0]  fw;
    logic         bz;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] pack_group();
    logic [127:0] w;
    w = {PAD, PAD, PAD, PAD};
    for (int i = 0; i < grp.size(); i++) w[i*32 +: 32] = grp[i];
    return w;
  endfunction

  // Compare DUT outputs against the model at the negedge, then advance the
  // model by the write and the accept that happen on the coming edge.
  task automatic monitor();
    logic pend;
    wr_t  e;
    pend = (exp_q.size() != 0);
    chk("in_ready", bus.in_ready, !pend || !bus.wr_full);
    chk("wr_en", bus.wr_en, pend && !bus.wr_full);
    chk("busy", bus.busy, pend || (grp.size() != 0));
    chk("frame_words", bus.frame_words, fw_model);
    if (pend) chk("wr_data", bus.wr_data, exp_q[0].data);
    if (pend && !bus.wr_full) begin
      chk("wr_last", bus.wr_last, exp_q[0].last);
      if (exp_q[0].last) fw_model = 0;
      else if (fw_model < FW_MAX) fw_model++;
      void'(exp_q.pop_front());
    end else begin
      chk("wr_last_idle", bus.wr_last, 1'b0);
    end
    acc_seen = bus.in_valid && bus.in_ready;
    if (acc_seen) begin
      grp.push_back(bus.in_data);
      if (grp.size() == 4 || bus.in_last) begin
        e.data = pack_group();
        e.last = bus.in_last;
        exp_q.push_back(e);
        grp.delete();
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    if (mon_en) monitor();
    else acc_seen = bus.in_valid && bus.in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_full();
    if (full_mode == 0) bus.wr_full = 1'b0;
    else if (full_mode == 1) bus.wr_full = 1'($urandom_range(0, 1));
  endtask

  task automatic send_word(input logic [31:0] d, input logic last, input int gap);
    int waits;
    waits = 0;
    if (gap > 0 && $urandom_range(0, 99) < gap) begin
      bus.in_valid = 1'b0;
      drive_full();
      cycle();
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    do begin
      drive_full();
      cycle();
      waits++;
    end while (!acc_seen && waits < 200);
    if (!acc_seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: word %h not accepted in 200 cycles", d);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_frame(input int n, input int gap);
    for (int i = 0; i < n; i++) send_word($urandom, (i == n - 1), gap);
  endtask

  task automatic drain();
    int waits;
    waits = 0;
    bus.in_valid = 1'b0;
    while (exp_q.size() != 0 && waits < 200) begin
      drive_full();
      cycle();
      waits++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d words still pending", exp_q.size());
    end
    bus.wr_full = 1'b0;
    cycle();
  endtask

  initial begin
    int k;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 32'h0;
    bus.in_last  = 1'b0;
    bus.wr_full  = 1'b0;

    // Table: single full word, single-word frame, and a held-full flush.
    tbl[0]  = '{1'b1, 32'h11111111, 1'b0, 1'b0, 1'b1, 1'b0, 128'h0, 1'b0, 11'd0, 1'b0};
    tbl[1]  = '{1'b1, 32'h22222222, 1'b0, 1'b0, 1'b1, 1'b0, 128'h0, 1'b0, 11'd0, 1'b1};
    tbl[2]  = '{1'b1, 32'h33333333, 1'b0, 1'b0, 1'b1, 1'b0, 128'h0, 1'b0, 11'd0, 1'b1};
    tbl[3]  = '{1'b1, 32'h44444444, 1'b0, 1'b0, 1'b1, 1'b0, 128'h0, 1'b0, 11'd0, 1'b1};
    tbl[4]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1,
                128'h44444444_33333333_22222222_11111111, 1'b0, 11'd0, 1'b1};
    tbl[5]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0,
                128'h44444444_33333333_22222222_11111111, 1'b0, 11'd1, 1'b0};
    tbl[6]  = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 1'b0,
                128'h44444444_33333333_22222222_11111111, 1'b0, 11'd1, 1'b0};
    tbl[7]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, {96'h0, 32'hDEADBEEF}, 1'b1, 11'd1, 1'b1};
    tbl[8]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, {96'h0, 32'hDEADBEEF}, 1'b0, 11'd0, 1'b0};
    tbl[9]  = '{1'b1, 32'hAAAA0000, 1'b1, 1'b1, 1'b1, 1'b0, {96'h0, 32'hDEADBEEF}, 1'b0, 11'd0, 1'b0};
    tbl[10] = '{1'b1, 32'hBBBB0000, 1'b0, 1'b1, 1'b0, 1'b0, {96'h0, 32'hAAAA0000}, 1'b0, 11'd0, 1'b1};
    tbl[11] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, {96'h0, 32'hAAAA0000}, 1'b1, 11'd0, 1'b1};
    tbl[12] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, {96'h0, 32'hAAAA0000}, 1'b0, 11'd0, 1'b0};

    // Reset values while rst is held
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_wr_en", bus.wr_en, 1'b0);
    chk("rst_wr_data", bus.wr_data, 128'h0);
    chk("rst_frame_words", bus.frame_words, 11'd0);
    chk("rst_busy", bus.busy, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      bus.in_valid = tbl[i].v;
      bus.in_data  = tbl[i].d;
      bus.in_last  = tbl[i].l;
      bus.wr_full  = tbl[i].f;
      @(negedge clk);
      chk($sformatf("row%0d_in_ready", i), bus.in_ready, tbl[i].rdy);
      chk($sformatf("row%0d_wr_en", i), bus.wr_en, tbl[i].we);
      chk($sformatf("row%0d_wr_data", i), bus.wr_data, tbl[i].wd);
      chk($sformatf("row%0d_wr_last", i), bus.wr_last, tbl[i].wl);
      chk($sformatf("row%0d_frame_words", i), bus.frame_words, tbl[i].fw);
      chk($sformatf("row%0d_busy", i), bus.busy, tbl[i].bz);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.wr_full  = 1'b0;

    // Model-checked phases from here on
    mon_en = 1'b1;

    // 6-word frame: second write carries two padded lanes and wr_last
    full_mode = 0;
    send_frame(6, 0);
    drain();

    // wr_full held for 20+ cycles with continuous in_valid
    full_mode = 2;
    bus.wr_full = 1'b1;
    k = 0;
    for (int c = 0; c < 24; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h3000_0000 + k;
      bus.in_last  = 1'b0;
      cycle();
      if (acc_seen) k++;
    end
    chk("full_accepted_count", k, 4);
    bus.wr_full = 1'b0;
    full_mode = 0;
    while (k < 12) begin
      send_word(32'h3000_0000 + k, (k == 11), 0);
      k++;
    end
    drain();

    // Reset mid-frame after two words
    send_word(32'h5000_0001, 1'b0, 0);
    send_word(32'h5000_0002, 1'b0, 0);
    rst = 1'b1;
    grp.delete();
    exp_q.delete();
    fw_model = 0;
    @(negedge clk);
    chk("midrst_wr_en", bus.wr_en, 1'b0);
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_frame_words", bus.frame_words, 11'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) send_word(32'h6000_0000 + i, 1'b0, 0);
    drain();
    send_word(32'h6000_00FF, 1'b1, 0);
    drain();

    // Back-to-back frames of 8 and 5 words with random wr_full
    full_mode = 1;
    send_frame(8, 30);
    send_frame(5, 30);
    drain();

    // Further random frames
    for (int f = 0; f < 12; f++) send_frame($urandom_range(1, 13), 25);
    drain();

    // frame_words saturation: 2049 full words in one frame
    full_mode = 0;
    for (int i = 0; i < 4 * 2049; i++) send_word($urandom, 1'b0, 0);
    drain();
    @(negedge clk);
    chk("frame_words_saturated", bus.frame_words, 11'h7FF);
    @(posedge clk);
    #1;
    send_word($urandom, 1'b1, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
